accumulator_fixedpoint: RTL

ACCUMULATOR_FIXEDPOINT -- requirements
Module: accumulator_fixedpoint

---
 rtl/accumulator_fixedpoint_pkg.sv | 22 ++
 rtl/adder_saturating_unsigned.sv | 19 +
 rtl/accumulator_fixedpoint.sv | 91 +++++++++
 3 files changed

// File: rtl/accumulator_fixedpoint_pkg.sv
// rtl/accumulator_fixedpoint_pkg.sv - shared FSM encoding and width helpers for the fixed-point accumulator
package accumulator_fixedpoint_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int term_width(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  function automatic int result_width(input int int_bits, input int frac_bits, input int guard_bits);
    return int_bits + frac_bits + guard_bits;
  endfunction

  // A single-term frame still needs a one-bit counter so the port/reg widths stay legal.
  function automatic int count_width(input int acc_length);
    return (acc_length > 1) ? $clog2(acc_length) : 1;
  endfunction

endpackage

// File: rtl/adder_saturating_unsigned.sv
// rtl/adder_saturating_unsigned.sv - unsigned add of a term into a wider accumulator, clamped to all-ones
module adder_saturating_unsigned #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 12
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [IN_WIDTH-1:0]  term,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow
);

  logic [ACC_WIDTH:0] full_sum;

  // One extra bit is enough: the carry out of ACC_WIDTH flags the wrap.
  assign full_sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, term};
  assign overflow = full_sum[ACC_WIDTH];
  assign sum      = overflow ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];

endmodule

// File: rtl/accumulator_fixedpoint.sv
// rtl/accumulator_fixedpoint.sv - sums ACC_LENGTH unsigned fixed-point terms per frame with saturation
module accumulator_fixedpoint
  import accumulator_fixedpoint_pkg::*;
#(
  parameter int INTEGER_BITWIDTH  = 4,
  parameter int FRACTION_BITWIDTH = 4,
  parameter int ACC_LENGTH        = 8,
  parameter int GUARD_BITWIDTH    = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic in_valid,
  output logic in_ready,
  input  logic [term_width(INTEGER_BITWIDTH, FRACTION_BITWIDTH)-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [result_width(INTEGER_BITWIDTH, FRACTION_BITWIDTH, GUARD_BITWIDTH)-1:0] out_data,
  output logic out_overflow
);

  localparam int W  = term_width(INTEGER_BITWIDTH, FRACTION_BITWIDTH);
  localparam int RW = result_width(INTEGER_BITWIDTH, FRACTION_BITWIDTH, GUARD_BITWIDTH);
  localparam int CW = count_width(ACC_LENGTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ACC_LENGTH - 1);

  state_t        state;
  logic [RW-1:0] acc;
  logic [RW-1:0] sum;
  logic          sum_overflow;
  logic          sticky;
  logic [CW-1:0] count;

  adder_saturating_unsigned #(
    .IN_WIDTH (W),
    .ACC_WIDTH(RW)
  ) u_adder (
    .acc     (acc),
    .term    (in_data),
    .sum     (sum),
    .overflow(sum_overflow)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ACCUM;
      acc          <= '0;
      count        <= '0;
      sticky       <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          // clear wins over a simultaneous term: that term is dropped, not summed.
          if (clear) begin
            acc    <= '0;
            count  <= '0;
            sticky <= 1'b0;
          end else if (in_valid && in_ready) begin
            if (count == LAST_COUNT) begin
              out_data     <= sum;
              out_overflow <= sticky | sum_overflow;
              acc          <= '0;
              count        <= '0;
              sticky       <= 1'b0;
              state        <= HOLD;
              out_valid    <= 1'b1;
              in_ready     <= 1'b0;
            end else begin
              acc    <= sum;
              sticky <= sticky | sum_overflow;
              count  <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
